// File: rtl/tune_scheduler_if.sv
// Request/level inputs and beat outputs exchanged between the cart controller and tune_scheduler.
interface tune_scheduler_if;
  logic        req_alarm;
  logic        req_horn;
  logic        music_en;
  logic        pause;
  logic [11:0] ibeat;
  logic [1:0]  song_sel;
  logic        beat_tick;
  logic        done;

  modport master (output req_alarm, req_horn, music_en, pause,
                  input  ibeat, song_sel, beat_tick, done);
  modport slave  (input  req_alarm, req_horn, music_en, pause,
                  output ibeat, song_sel, beat_tick, done);
endinterface

// File: rtl/tune_scheduler.sv
// Fixed-priority arbiter and beat sequencer for alarm, horn and background music tunes.
// Music position survives one-shot interruptions; a preempted horn restarts later from beat 0.
module tune_scheduler #(
  parameter int BEAT_DIV  = 25_000_000,
  parameter int LEN_ALARM = 16,
  parameter int LEN_HORN  = 8,
  parameter int LEN_MUSIC = 512
) (
  input  logic            clk,
  input  logic            reset,
  tune_scheduler_if.slave bus
);
  localparam int            DW       = $clog2(BEAT_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(BEAT_DIV - 1);
  localparam logic [11:0]   LAST_A   = 12'(LEN_ALARM - 1);
  localparam logic [11:0]   LAST_H   = 12'(LEN_HORN - 1);
  localparam logic [11:0]   LAST_M   = 12'(LEN_MUSIC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MUSIC = 2'd1, HORN = 2'd2, ALARM = 2'd3} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div, div_nx;
  logic [11:0]   ibeat, ibeat_nx, music_pos, music_pos_nx;
  logic          pend_alarm, pend_horn, pa_nx, ph_nx;
  logic          tick, tick_nx, done, done_nx;
  logic          beat, want_alarm, want_horn;

  always_comb begin
    beat         = (state != IDLE) && !bus.pause && (div == DIV_LAST);
    // A request for the tune already playing never registers.
    want_alarm   = pend_alarm | (bus.req_alarm && state != ALARM);
    want_horn    = pend_horn  | (bus.req_horn  && state != HORN);
    state_nx     = state;
    div_nx       = div;
    ibeat_nx     = ibeat;
    music_pos_nx = music_pos;
    pa_nx        = want_alarm;
    ph_nx        = want_horn;
    tick_nx      = 1'b0;
    done_nx      = 1'b0;

    if (!bus.pause) begin
      unique case (state)
        IDLE, MUSIC: begin
          if (want_alarm)                       state_nx = ALARM;
          else if (want_horn)                   state_nx = HORN;
          else if (state == IDLE && bus.music_en) state_nx = MUSIC;
          else if (state == MUSIC && !bus.music_en) state_nx = IDLE;
        end
        HORN: begin
          if (want_alarm) state_nx = ALARM;
          else if (beat && ibeat == LAST_H) begin
            done_nx  = 1'b1;
            state_nx = bus.music_en ? MUSIC : IDLE;
          end
        end
        ALARM: begin
          if (beat && ibeat == LAST_A) begin
            done_nx  = 1'b1;
            state_nx = want_horn ? HORN : (bus.music_en ? MUSIC : IDLE);
          end
        end
      endcase

      if (state_nx != state) begin
        // State change: no tick, divider restarts so the first beat is full length.
        div_nx   = '0;
        ibeat_nx = (state_nx == MUSIC) ? music_pos : 12'd0;
        if (state_nx == ALARM) pa_nx = 1'b0;
        if (state_nx == HORN)  ph_nx = 1'b0;
        if (state == HORN && !done_nx) ph_nx = 1'b1;
        if (state == MUSIC) music_pos_nx = bus.music_en ? ibeat : 12'd0;
      end else if (state != IDLE) begin
        div_nx = beat ? '0 : div + 1'b1;
        if (beat) begin
          tick_nx  = 1'b1;
          ibeat_nx = (state == MUSIC && ibeat == LAST_M) ? 12'd0 : ibeat + 12'd1;
        end
      end
    end

    if (!bus.music_en && state != MUSIC) music_pos_nx = 12'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      div        <= '0;
      ibeat      <= '0;
      music_pos  <= '0;
      pend_alarm <= 1'b0;
      pend_horn  <= 1'b0;
      tick       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      div        <= div_nx;
      ibeat      <= ibeat_nx;
      music_pos  <= music_pos_nx;
      pend_alarm <= pa_nx;
      pend_horn  <= ph_nx;
      tick       <= tick_nx;
      done       <= done_nx;
    end
  end

  assign bus.ibeat     = ibeat;
  assign bus.song_sel  = state;
  assign bus.beat_tick = tick;
  assign bus.done      = done;
endmodule
